fir_ntap_stream: RTL
====================

# fir_ntap_stream

Parametrised N-tap transposed-form FIR filter with run-time programmable coefficients and valid/ready streaming on input and output. Output is rounded and saturated. It succeeds the fixed 3-tap datapath and its controller: one self-contained block that drops into the same sample path, with the external load-strobe sequencing replaced by a handshake. Default coefficients reset to zero; software loads taps through a simple write port.

## Interface
Parameters:
- DATAWIDTH, 16, signed input sample width
- COEF_WIDTH, 16, signed coefficient width (Q format, FRAC_BITS fractional bits)
- FRAC_BITS, 8, fractional bits of coefficients; output shift amount
- NTAPS, 8, tap count (≥2)
- OUT_WIDTH, 16, signed output width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block accepts sample this cycle
- in_data  in  DATAWIDTH  signed sample x[n]
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts output
- out_data  out  OUT_WIDTH  signed filtered y[n]
- coef_wr  in  1  coefficient write strobe
- coef_addr  in  $clog2(NTAPS)  tap index k (h_k multiplies x[n-k])
- coef_data  in  COEF_WIDTH  signed coefficient value
- flush  in  1  synchronous clear of delay line and pipeline
- sat_sticky  out  1  set when any output saturated; cleared by flush/reset

## Operation
- advance = !out_valid || out_ready; in_ready = advance && !flush (combinational).
- Stage 1: on in_valid && in_ready, x_reg <= in_data, s1_valid <= 1; else if advance, s1_valid <= 0.
- Stage 2 (when s1_valid && advance): acc = x_reg*h0 + z1; z_k <= x_reg*h_k + z_{k+1} for k=1..NTAPS-2; z_{NTAPS-1} <= x_reg*h_{NTAPS-1}; out_data <= sat(round(acc)); out_valid <= 1.
- If out_valid && out_ready and no new stage-2 result, out_valid <= 0.
- Bubbles (s1_valid=0) do not shift the delay line; filter state advances only on real samples.
- Widths: product DATAWIDTH+COEF_WIDTH; ACC_WIDTH = DATAWIDTH+COEF_WIDTH+$clog2(NTAPS); all z_k ACC_WIDTH, sign-extended.
- round: add 2^(FRAC_BITS-1) in ACC_WIDTH+1 bits, then arithmetic shift right FRAC_BITS (round half up).
- sat: clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; clamping sets sat_sticky.
- Coefficient write: h[coef_addr] <= coef_data on coef_wr; addr ≥ NTAPS ignored. Allowed any time; used from the next stage-2 computation. Partial sums already in z keep old coefficients.
- flush: clears s1_valid, out_valid, all z_k, x_reg, sat_sticky; coefficients retained. flush wins over simultaneous in_valid (sample not accepted).

## Timing
- Reset (rst=0, async): in_ready=1 after release, out_valid=0, out_data=0, sat_sticky=0, all z_k=0, all h_k=0, x_reg=0.
- Latency: sample accepted at edge t → out_valid high after edge t+1 (2 cycles from in_valid sampled to out_data visible).
- Throughput: one sample/cycle with out_ready held high.
- Backpressure: out_valid && !out_ready freezes x_reg, z chain, and out_data; in_ready low; nothing dropped or duplicated.
- out_data stable while out_valid && !out_ready.
- Reset mid-stream: all state cleared immediately; in-flight samples discarded.

## Structure
- Package fir_pkg: default parameter constants, ACC_WIDTH function, round/saturate function shared with other filter blocks.
- Sub-module fir_tap_cell: one transposed tap (multiplier, adder, enable-gated z register, sync clear). It is instantiated NTAPS-1 times via generate. The h0 output path stays in the top module.

## Test plan
- Impulse: h0..h2=0x0040,0x0080,0x0040, rest 0; x=0x0100 then zeros → out 0x0040, 0x0080, 0x0040, 0x0000…
- Step: same coefficients, x=0x0100 continuous → 0x0040, 0x00C0, 0x0100, 0x0100…; sat_sticky=0.
- Saturation: h0=h1=0x0100, x=0x7FFF repeated → 0x7FFF, 0x7FFF(clamped), sat_sticky=1. With x=0x8000 → 0x8000 held; flush clears sat_sticky.
- Rounding: h0=0x0080 only; x=0x0001 → 0x0001; x=0xFFFF → 0x0000; x=0x0003 → 0x0002.
- Backpressure/bubbles: random in_valid gaps, out_ready low 5 cycles → in_ready low, out_data stable, output stream matches golden model sample-for-sample.
- Reset/flush/coef update mid-stream: assert rst during burst → all outputs to reset values at once. flush with in_valid=1 → sample not taken. Write h1 during stream → subsequent outputs match model using the new h1 only for partial sums computed after the write.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: constants and helpers shared by the streaming FIR filter blocks.
//   - default parameter values for the filter datapath
//   - acc_width(): accumulator width that cannot overflow for a given tap count
//   - round_sat(): round-half-up, arithmetic shift and clamp to the output range
package fir_pkg;

    localparam int DEF_DATAWIDTH  = 16;
    localparam int DEF_COEF_WIDTH = 16;
    localparam int DEF_FRAC_BITS  = 8;
    localparam int DEF_NTAPS      = 8;
    localparam int DEF_OUT_WIDTH  = 16;

    // Working width of round_sat(); accumulators up to RS_WIDTH-1 bits fit
    // with one spare bit for the rounding addend.
    localparam int RS_WIDTH = 64;

    typedef struct packed {
        logic                       sat;    // result was clamped
        logic signed [RS_WIDTH-1:0] value;  // rounded, clamped result
    } rs_t;

    function automatic int acc_width(input int dw, input int cw, input int ntaps);
        return dw + cw + $clog2(ntaps);
    endfunction

    // Adds half an output LSB, shifts out the fractional bits (round half up)
    // and clamps to the signed out_width range.
    function automatic rs_t round_sat(input logic signed [RS_WIDTH-1:0] acc,
                                      input int frac_bits,
                                      input int out_width);
        logic signed [RS_WIDTH-1:0] half;
        logic signed [RS_WIDTH-1:0] rounded;
        logic signed [RS_WIDTH-1:0] max_v;
        logic signed [RS_WIDTH-1:0] min_v;
        rs_t r;
        half    = (frac_bits > 0) ? (64'sd1 <<< (frac_bits - 1)) : 64'sd0;
        rounded = (acc + half) >>> frac_bits;
        max_v   = (64'sd1 <<< (out_width - 1)) - 64'sd1;
        min_v   = -(64'sd1 <<< (out_width - 1));
        r.sat   = 1'b0;
        r.value = rounded;
        if (rounded > max_v) begin
            r.value = max_v;
            r.sat   = 1'b1;
        end else if (rounded < min_v) begin
            r.value = min_v;
            r.sat   = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_tap_cell.sv
// fir_tap_cell: one transposed-form FIR tap.
//   z_out <= x*h + z_in when en; cleared by clr (sync) or rst (async, active-low).
// Ports:
//   clk, rst    clock, asynchronous active-low reset
//   en          shift enable (a real sample is in stage 2)
//   clr         synchronous clear of the partial sum
//   x, h        sample and this tap's coefficient
//   z_in        partial sum from the next-higher tap (0 for the last tap)
//   z_out       registered partial sum handed to the next-lower tap
module fir_tap_cell
    import fir_pkg::*;
#(
    parameter int DATAWIDTH  = DEF_DATAWIDTH,
    parameter int COEF_WIDTH = DEF_COEF_WIDTH,
    parameter int ACC_WIDTH  = acc_width(DEF_DATAWIDTH, DEF_COEF_WIDTH, DEF_NTAPS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         clr,
    input  logic signed [DATAWIDTH-1:0]  x,
    input  logic signed [COEF_WIDTH-1:0] h,
    input  logic signed [ACC_WIDTH-1:0]  z_in,
    output logic signed [ACC_WIDTH-1:0]  z_out
);

    localparam int PW = DATAWIDTH + COEF_WIDTH;

    logic signed [PW-1:0] prod;

    // Operands widened first so the signed product is computed at full width.
    assign prod = PW'(x) * PW'(h);

    // NOTE: registers use non-blocking assignments so every tap samples the
    // pre-edge value of its neighbour; blocking here would ripple the chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            z_out <= '0;
        end else if (clr) begin
            z_out <= '0;
        end else if (en) begin
            z_out <= ACC_WIDTH'(prod) + z_in;
        end
    end

endmodule

// File: rtl/fir_ntap_stream.sv
// fir_ntap_stream: N-tap transposed-form FIR with programmable coefficients,
// valid/ready streaming, round-half-up and saturation of the output.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   in_valid/in_ready/in_data      input sample stream x[n]
//   out_valid/out_ready/out_data   output stream y[n]
//   coef_wr/coef_addr/coef_data    coefficient write port (h_k multiplies x[n-k])
//   flush                          sync clear of delay line and pipeline
//   sat_sticky                     set when any output was clamped
module fir_ntap_stream
    import fir_pkg::*;
#(
    parameter int DATAWIDTH  = DEF_DATAWIDTH,
    parameter int COEF_WIDTH = DEF_COEF_WIDTH,
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    parameter int NTAPS      = DEF_NTAPS,
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATAWIDTH-1:0]  in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [OUT_WIDTH-1:0]  out_data,
    input  logic                         coef_wr,
    input  logic [$clog2(NTAPS)-1:0]     coef_addr,
    input  logic signed [COEF_WIDTH-1:0] coef_data,
    input  logic                         flush,
    output logic                         sat_sticky
);

    localparam int AW        = $clog2(NTAPS);
    localparam int PW        = DATAWIDTH + COEF_WIDTH;
    localparam int ACC_WIDTH = acc_width(DATAWIDTH, COEF_WIDTH, NTAPS);

    logic signed [COEF_WIDTH-1:0] h [NTAPS];
    logic signed [DATAWIDTH-1:0]  x_reg;
    logic                         s1_valid;
    logic                         advance;
    logic                         shift_en;
    logic                         addr_ok;
    logic signed [ACC_WIDTH-1:0]  z_chain [1:NTAPS];
    logic signed [PW-1:0]         p0;
    logic signed [ACC_WIDTH-1:0]  acc;
    rs_t                          rs;
    logic                         unused_rs_hi;

    // The output register can take a new result when empty or being drained.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && !flush;
    // Bubbles leave the delay line untouched; only real samples shift it.
    assign shift_en = s1_valid && advance;

    // Out-of-range addresses only exist when NTAPS is not a power of two.
    generate
        if ((1 << AW) == NTAPS) begin : g_addr_full
            assign addr_ok = 1'b1;
        end else begin : g_addr_chk
            assign addr_ok = (32'(coef_addr) < NTAPS);
        end
    endgenerate

    // NOTE: the coefficient array is a small register file, not RAM, so it
    // takes the async reset like any other state (taps power up as zero).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NTAPS; k++) h[k] <= '0;
        end else if (coef_wr && addr_ok) begin
            h[coef_addr] <= coef_data;
        end
    end

    // Stage 1: input sample register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_reg    <= '0;
            s1_valid <= 1'b0;
        end else if (flush) begin
            x_reg    <= '0;
            s1_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            x_reg    <= in_data;
            s1_valid <= 1'b1;
        end else if (advance) begin
            s1_valid <= 1'b0;
        end
    end

    // Transposed delay line: tap k feeds tap k-1; the last tap starts from 0.
    assign z_chain[NTAPS] = '0;

    generate
        for (genvar k = 1; k < NTAPS; k++) begin : g_tap
            fir_tap_cell #(
                .DATAWIDTH  (DATAWIDTH),
                .COEF_WIDTH (COEF_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH)
            ) u_tap (
                .clk   (clk),
                .rst   (rst),
                .en    (shift_en),
                .clr   (flush),
                .x     (x_reg),
                .h     (h[k]),
                .z_in  (z_chain[k+1]),
                .z_out (z_chain[k])
            );
        end
    endgenerate

    // Stage 2: h0 term closes the sum, then round and clamp.
    assign p0  = PW'(x_reg) * PW'(h[0]);
    assign acc = ACC_WIDTH'(p0) + z_chain[1];
    assign rs  = round_sat(RS_WIDTH'(acc), FRAC_BITS, OUT_WIDTH);

    // Bits above OUT_WIDTH are pure sign after clamping.
    assign unused_rs_hi = ^rs.value[RS_WIDTH-1:OUT_WIDTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            sat_sticky <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            sat_sticky <= 1'b0;
        end else if (shift_en) begin
            out_data  <= rs.value[OUT_WIDTH-1:0];
            out_valid <= 1'b1;
            if (rs.sat) sat_sticky <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
